// File: rtl/sseg_bcd_scan_pkg.sv
// Shared segment codes, conversion FSM states and the BCD digit decoder
// for the scanned seven-segment display driver.
package sseg_pkg;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_DASH  = 8'hFD;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Non-BCD nibbles cannot come out of double-dabble; show a dash if they ever do.
    function automatic logic [7:0] digit_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/sseg_bcd_scan_prescale.sv
// Scan prescaler: advances the digit index every DIV_MAX+1 clocks and
// flags the clock on which the index wraps back to digit 0.
module sseg_prescale #(
    parameter int DIV_MAX = 2200,
    parameter int DIGITS  = 4,
    localparam int CNT_W  = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1,
    localparam int IDX_W  = $clog2(DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] scan_idx,
    output logic             frame_tick
);

    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic             term_s;

    assign term_s     = (cnt_r == CNT_W'(DIV_MAX));
    assign frame_tick = term_s && (idx_r == IDX_W'(DIGITS - 1));
    assign scan_idx   = idx_r;

    // Prescaler and digit index; the index wraps explicitly so DIGITS need not be 2^n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (term_s) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= (idx_r == IDX_W'(DIGITS - 1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            idx_r <= idx_r;
        end
    end

endmodule

// File: rtl/sseg_bcd_scan.sv
// Binary-to-BCD (double-dabble, one bit per clock) display driver with digit scan.
// Optional feature macro SSEG_BLINK_EN adds the BLINK input and blink counter.
module sseg_bcd_scan
    import sseg_pkg::*;
#(
    parameter int BIN_W   = 16,
    parameter int DIGITS  = 4,
    parameter int DIV_MAX = 2200
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [BIN_W-1:0]  BIN_IN,
    input  logic              SIGN,
    input  logic              VALID,
    input  logic              START,
`ifdef SSEG_BLINK_EN
    input  logic              BLINK,
`endif
    output logic              BUSY,
    output logic              DONE,
    output logic              OVF,
    output logic [DIGITS-1:0] DISP_EN,
    output logic [7:0]        SEGMENTS
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int BCN_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    state_t                   state_r, state_s;
    logic [BIN_W-1:0]         bin_r;
    logic                     sign_r, valid_r, ovf_acc_r;
    logic [BCD_W-1:0]         bcd_r, adj_s;
    logic [BCN_W-1:0]         bitcnt_r;
    logic [DIGITS-1:0][7:0]   disp_r, disp_s;
    logic                     busy_r, done_r, ovf_r, ovf_eff_s, lead_s;
    logic [3:0]               nib_s;
    logic [IDX_W-1:0]         scan_idx_s;
    logic                     frame_tick_s;
    logic [DIGITS-1:0]        en_s;

    // Next-state logic of the conversion FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (START) state_s = SHIFT; else state_s = IDLE;
            SHIFT:   if (bitcnt_r == BCN_W'(0)) state_s = LOAD; else state_s = SHIFT;
            LOAD:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Add-3 correction of every nibble ahead of the shift.
    always_comb begin
        adj_s = bcd_r;
        for (int n = 0; n < DIGITS; n++) begin
            if (bcd_r[4*n +: 4] >= 4'd5) adj_s[4*n +: 4] = bcd_r[4*n +: 4] + 4'd3;
            else                         adj_s[4*n +: 4] = bcd_r[4*n +: 4];
        end
    end

    // Digit decode of the finished conversion, built from the leftmost digit down.
    always_comb begin
        ovf_eff_s = valid_r & (ovf_acc_r | (sign_r & (|bcd_r[BCD_W-1 -: 4])));
        lead_s    = 1'b1;
        nib_s     = 4'd0;
        disp_s    = {DIGITS{SEG_BLANK}};
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib_s = bcd_r[4*d +: 4];
            if (!valid_r || ovf_eff_s)                   disp_s[d] = SEG_DASH;
            else if (sign_r && (d == DIGITS - 1))        disp_s[d] = SEG_DASH;
            else if (lead_s && (nib_s == 4'd0) && d > 0) disp_s[d] = SEG_BLANK;
            else                                         disp_s[d] = digit_to_seg(nib_s);
            lead_s = lead_s & (nib_s == 4'd0);
        end
    end

    // Conversion datapath: operand capture and the shift/overflow sequence.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r   <= IDLE;
            bin_r     <= {BIN_W{1'b0}};
            sign_r    <= 1'b0;
            valid_r   <= 1'b0;
            bcd_r     <= {BCD_W{1'b0}};
            bitcnt_r  <= {BCN_W{1'b0}};
            ovf_acc_r <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (START) begin
                        bin_r     <= BIN_IN;
                        sign_r    <= SIGN;
                        valid_r   <= VALID;
                        bcd_r     <= {BCD_W{1'b0}};
                        bitcnt_r  <= BCN_W'(BIN_W - 1);
                        ovf_acc_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcd_r     <= {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
                    bin_r     <= bin_r << 1;
                    ovf_acc_r <= ovf_acc_r | adj_s[BCD_W-1];
                    bitcnt_r  <= bitcnt_r - BCN_W'(1);
                end
                default: begin
                    bcd_r <= bcd_r;
                end
            endcase
        end
    end

    // Handshake flags and the display register, which changes only in LOAD.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            disp_r <= {DIGITS{SEG_BLANK}};
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == LOAD);
            if (state_r == LOAD) begin
                disp_r <= disp_s;
                ovf_r  <= ovf_eff_s;
            end
        end
    end

    sseg_prescale #(
        .DIV_MAX (DIV_MAX),
        .DIGITS  (DIGITS)
    ) u_prescale (
        .clk        (CLK),
        .rst_n      (RST_N),
        .scan_idx   (scan_idx_s),
        .frame_tick (frame_tick_s)
    );

    // One-hot active-low enable of the digit currently being scanned.
    always_comb begin
        en_s             = {DIGITS{1'b1}};
        en_s[scan_idx_s] = 1'b0;
    end

`ifdef SSEG_BLINK_EN
    logic [6:0] blink_cnt_r;

    // Frame counter: the display goes dark for the upper half of each 128 frames.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)            blink_cnt_r <= 7'd0;
        else if (frame_tick_s) blink_cnt_r <= blink_cnt_r + 7'd1;
        else                   blink_cnt_r <= blink_cnt_r;
    end

    assign DISP_EN = (BLINK && blink_cnt_r[6]) ? {DIGITS{1'b1}} : en_s;
`else
    logic unused_tick_s;
    assign unused_tick_s = frame_tick_s;
    assign DISP_EN       = en_s;
`endif

    assign SEGMENTS = disp_r[scan_idx_s];
    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign OVF      = ovf_r;

endmodule
